// File: rtl/alt_mlab_fifo.sv
// alt_mlab_fifo: single-clock show-ahead FIFO on MLAB storage.
// A registered write stage feeds the MLAB one edge after a push, and a
// registered head word is loaded from the asynchronous read port.
// Total capacity is DEPTH memory words plus the output register.

module alt_mlab #(
   parameter int        WIDTH       = 64,
   parameter int        ADDR_WIDTH  = 5,
   parameter logic      SIM_EMULATE = 1'b0
) (
   input  logic                  wclk,
   input  logic                  wena,
   input  logic [ADDR_WIDTH-1:0] waddr_reg,
   input  logic [WIDTH-1:0]      wdata_reg,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      dout
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   generate
      if (SIM_EMULATE) begin : g_emu
         logic [WIDTH-1:0] mem [DEPTH];
         // Behavioural storage: synchronous write, asynchronous read.
         always_ff @(posedge wclk) begin
            if (wena) begin
               mem[waddr_reg] <= wdata_reg;
            end
         end
         assign dout = mem[raddr];
      end else begin : g_mlab
         (* ramstyle = "MLAB" *) logic [WIDTH-1:0] mem [DEPTH];
         // MLAB-mapped storage: synchronous write, asynchronous read.
         always_ff @(posedge wclk) begin
            if (wena) begin
               mem[waddr_reg] <= wdata_reg;
            end
         end
         assign dout = mem[raddr];
      end
   endgenerate
endmodule

module alt_mlab_fifo #(
   parameter int   WIDTH       = 64,
   parameter int   ADDR_WIDTH  = 5,
   parameter int   AF_THRESH   = (1 << ADDR_WIDTH) - 2,
   parameter logic SIM_EMULATE = 1'b0
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [WIDTH-1:0]      dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [ADDR_WIDTH:0]   used,
   output logic                  almost_full
);
   localparam int                 CW       = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]      DEPTH_C  = CW'(1 << ADDR_WIDTH);
   localparam logic [CW-1:0]      AF_C     = CW'(AF_THRESH);
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wptr_r, wptr_commit_r, rptr_r, waddr_r;
   logic                  wena_r;
   logic [WIDTH-1:0]      wdata_r, dout_r, rdata_s;
   logic [CW-1:0]         mem_occ_r, used_r;
   logic                  dout_valid_r, din_ready_r, almost_full_r;

   logic                  push_s, pop_s, readable_s, load_s;
   logic [CW-1:0]         mem_occ_next_s, used_next_s;
   logic                  dout_valid_next_s;

   alt_mlab #(
      .WIDTH       (WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .SIM_EMULATE (SIM_EMULATE)
   ) u_mlab (
      .wclk      (clk),
      .wena      (wena_r),
      .waddr_reg (waddr_r),
      .wdata_reg (wdata_r),
      .raddr     (rptr_r),
      .dout      (rdata_s)
   );

   // Handshakes, readability and next-state occupancy/flags.
   always_comb begin
      push_s = din_valid & din_ready_r;
      pop_s  = dout_valid_r & dout_ready;
      // Pointer equality is ambiguous when the memory holds DEPTH committed
      // words, so that case is resolved from the occupancy counter.
      readable_s = (rptr_r != wptr_commit_r) | ((mem_occ_r == DEPTH_C) & ~wena_r);
      load_s = (~dout_valid_r | pop_s) & readable_s;

      mem_occ_next_s = mem_occ_r;
      if (flush) begin
         mem_occ_next_s = '0;
      end else begin
         case ({push_s, load_s})
            2'b10:   mem_occ_next_s = mem_occ_r + CNT_ONE;
            2'b01:   mem_occ_next_s = mem_occ_r - CNT_ONE;
            default: mem_occ_next_s = mem_occ_r;
         endcase
      end

      dout_valid_next_s = dout_valid_r;
      if (flush) begin
         dout_valid_next_s = 1'b0;
      end else if (load_s) begin
         dout_valid_next_s = 1'b1;
      end else if (pop_s) begin
         dout_valid_next_s = 1'b0;
      end else begin
         dout_valid_next_s = dout_valid_r;
      end

      used_next_s = mem_occ_next_s + {{ADDR_WIDTH{1'b0}}, dout_valid_next_s};
   end

   // Write stage: capture the pushed word, commit it to the MLAB next edge.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wena_r        <= 1'b0;
         waddr_r       <= '0;
         wdata_r       <= '0;
         wptr_r        <= '0;
         wptr_commit_r <= '0;
      end else if (flush) begin
         wena_r        <= 1'b0;
         wptr_r        <= '0;
         wptr_commit_r <= '0;
      end else begin
         wena_r <= push_s;
         if (push_s) begin
            waddr_r <= wptr_r;
            wdata_r <= din;
            wptr_r  <= wptr_r + PTR_ONE;
         end
         if (wena_r) begin
            wptr_commit_r <= wptr_commit_r + PTR_ONE;
         end
      end
   end

   // Read side: load the head word and advance the read pointer.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rptr_r       <= '0;
         dout_r       <= '0;
         dout_valid_r <= 1'b0;
      end else if (flush) begin
         rptr_r       <= '0;
         dout_valid_r <= 1'b0;
      end else begin
         dout_valid_r <= dout_valid_next_s;
         if (load_s) begin
            dout_r <= rdata_s;
            rptr_r <= rptr_r + PTR_ONE;
         end
      end
   end

   // Occupancy counter and registered status flags.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         mem_occ_r     <= '0;
         used_r        <= '0;
         din_ready_r   <= 1'b0;
         almost_full_r <= 1'b0;
      end else begin
         mem_occ_r     <= mem_occ_next_s;
         used_r        <= used_next_s;
         din_ready_r   <= (mem_occ_next_s < DEPTH_C);
         almost_full_r <= (used_next_s >= AF_C);
      end
   end

   assign din_ready   = din_ready_r;
   assign dout        = dout_r;
   assign dout_valid  = dout_valid_r;
   assign used        = used_r;
   assign almost_full = almost_full_r;
endmodule

// File: tb/tb_alt_mlab_fifo.sv
// tb_alt_mlab_fifo: table-driven bench with a data scoreboard for alt_mlab_fifo
// (WIDTH=16, DEPTH=8, AF_THRESH=6).

module tb_alt_mlab_fifo;
   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        flush = 1'b0;
   logic [15:0] din = 16'h0000;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic [15:0] dout;
   logic        dout_valid;
   logic        dout_ready = 1'b0;
   logic [3:0]  used;
   logic        almost_full;

   typedef struct {
      logic        dv;
      logic [15:0] d;
      logic        dr;
      logic        fl;
      logic        exp_dv;
      logic [3:0]  exp_used;
      logic        exp_rdy;
      logic        exp_af;
   } vec_t;

   vec_t        tbl[$];
   logic [15:0] sb_q[$];
   int          checks = 0;
   int          errors = 0;

   alt_mlab_fifo #(
      .WIDTH       (16),
      .ADDR_WIDTH  (3),
      .AF_THRESH   (6),
      .SIM_EMULATE (1'b1)
   ) dut (
      .clk         (clk),
      .arst        (arst),
      .flush       (flush),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .used        (used),
      .almost_full (almost_full)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic dv, input logic [15:0] d, input logic dr,
                               input logic fl, input logic edv, input int eu,
                               input logic erdy, input logic eaf);
      vec_t v;
      v.dv = dv; v.d = d; v.dr = dr; v.fl = fl;
      v.exp_dv = edv; v.exp_used = 4'(eu); v.exp_rdy = erdy; v.exp_af = eaf;
      return v;
   endfunction

   task automatic check1(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d actual=%0h required=%0h", name, idx, act, exp);
      end
   endtask

   // One clock step: drive, check head word against scoreboard, clock, check flags.
   task automatic step(input vec_t v, input int idx);
      logic push, pop;
      din_valid  = v.dv;
      din        = v.d;
      dout_ready = v.dr;
      flush      = v.fl;
      #1;
      push = din_valid & din_ready;
      pop  = dout_valid & dout_ready;
      if (dout_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dout_unexpected step %0d actual=%0h required=none", idx, dout);
         end else begin
            check1("dout", idx, 32'(dout), 32'(sb_q[0]));
         end
      end
      @(posedge clk);
      #1;
      if (v.fl) begin
         sb_q.delete();
      end else begin
         if (pop && sb_q.size() != 0) void'(sb_q.pop_front());
         if (push) sb_q.push_back(v.d);
      end
      check1("dout_valid", idx, 32'(dout_valid), 32'(v.exp_dv));
      check1("used", idx, 32'(used), 32'(v.exp_used));
      check1("din_ready", idx, 32'(din_ready), 32'(v.exp_rdy));
      check1("almost_full", idx, 32'(almost_full), 32'(v.exp_af));
   endtask

   initial begin
      // Idle edge after reset release.
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0));
      // Single push, two-edge latency, stable head, then drain.
      tbl.push_back(mk(1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0));
      // Fill to DEPTH+1 with no consumer.
      for (int k = 0; k < 9; k++)
         tbl.push_back(mk(1'b1, 16'(k), 1'b0, 1'b0, k >= 2, k + 1, k != 8, (k + 1) >= 6));
      // Drain the full FIFO.
      for (int p = 1; p <= 9; p++)
         tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, p < 9, 9 - p, 1'b1, (9 - p) >= 6));
      // Streaming across pointer wrap, then drain.
      for (int i = 0; i < 20; i++)
         tbl.push_back(mk(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0, i >= 2, (i < 2) ? i + 1 : 3,
                          1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0));
      // Flush with a concurrent push, then a fresh push.
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(1'b1, 16'h0200 + 16'(k), 1'b0, 1'b0, k >= 2, k + 1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0));
      // Burst that the asynchronous reset interrupts.
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(1'b1, 16'h0300 + 16'(k), 1'b0, 1'b0, k >= 2, k + 1, 1'b1, 1'b0));

      // Reset state.
      #1;
      check1("rst_dout_valid", -1, 32'(dout_valid), 32'd0);
      check1("rst_din_ready", -1, 32'(din_ready), 32'd0);
      check1("rst_used", -1, 32'(used), 32'd0);
      check1("rst_almost_full", -1, 32'(almost_full), 32'd0);
      check1("rst_dout", -1, 32'(dout), 32'd0);
      #11;
      arst = 1'b0;
      #1;
      check1("rel_din_ready", -1, 32'(din_ready), 32'd0);

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // Asynchronous reset between edges with words in flight.
      #3;
      arst = 1'b1;
      #1;
      check1("arst_dout_valid", 100, 32'(dout_valid), 32'd0);
      check1("arst_din_ready", 100, 32'(din_ready), 32'd0);
      check1("arst_used", 100, 32'(used), 32'd0);
      check1("arst_almost_full", 100, 32'(almost_full), 32'd0);
      check1("arst_dout", 100, 32'(dout), 32'd0);
      sb_q.delete();
      #2;
      arst = 1'b0;
      for (int i = 0; i < 4; i++)
         step(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0), 200 + i);
      step(mk(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0), 210);
      step(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0), 211);
      step(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0), 212);
      step(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0), 213);
      check1("sb_empty_at_end", 214, 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
